// File: rtl/sic4_pkg.sv
// Shared SIC-4 decode definitions: default field widths, opcode encodings and
// the decoded-instruction record.
package sic4_pkg;

   localparam int SIC4_OP_W   = 2;
   localparam int SIC4_REG_W  = 2;
   localparam int SIC4_IMM_W  = 2;
   localparam int SIC4_DATA_W = 8;

   localparam logic [1:0] OP_RTYPE   = 2'b00;
   localparam logic [1:0] OP_IMM     = 2'b01;
   localparam logic [1:0] OP_LOAD    = 2'b10;
   localparam logic [1:0] OP_NOWRITE = 2'b11;

   typedef struct packed {
      logic [SIC4_OP_W-1:0]   op;
      logic [SIC4_REG_W-1:0]  rtd;
      logic [SIC4_REG_W-1:0]  rs;
      logic [SIC4_IMM_W-1:0]  fun_imm;
      logic [SIC4_DATA_W-1:0] imm_sext;
      logic                   wr_en;
   } decoded_t;

endpackage

// File: rtl/decode_stage_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, writeback clear then accept
// set, plus two bypassed lookup ports used for hazard detection.
module reg_scoreboard #(
   parameter int REG_W = 2,
   localparam int NREG = 2**REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_reg,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_reg,
   input  logic [REG_W-1:0] rd_a,
   input  logic [REG_W-1:0] rd_b,
   output logic             hit_a,
   output logic             hit_b,
   output logic [NREG-1:0]  busy
);

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;
   logic [NREG-1:0] wb_mask_s;
   logic [NREG-1:0] set_mask_s;
   logic [NREG-1:0] eff_pend_s;

   // Decode writeback/set one-hot masks; a retiring register no longer stalls.
   always_comb begin
      wb_mask_s  = '0;
      set_mask_s = '0;
      if (wb_valid) begin
         wb_mask_s = NREG'(1) << wb_reg;
      end else begin
         wb_mask_s = '0;
      end
      if (set_en) begin
         set_mask_s = NREG'(1) << set_reg;
      end else begin
         set_mask_s = '0;
      end
      eff_pend_s = pending_q & ~wb_mask_s;
      // Set is applied after clear so a new writer of the retiring register wins.
      pending_d  = eff_pend_s | set_mask_s;
   end

   // Pending vector register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign hit_a = eff_pend_s[rd_a];
   assign hit_b = eff_pend_s[rd_b];
   assign busy  = pending_q;

endmodule

// File: rtl/decode_stage.sv
// SIC-4 registered decode stage with scoreboard hazard stall and valid/ready
// handshake. Optional DECODE_STAGE_PERF_EN adds stall/issue counters.
module decode_stage
   import sic4_pkg::*;
#(
   parameter int              OP_W       = SIC4_OP_W,
   parameter int              REG_W      = SIC4_REG_W,
   parameter int              IMM_W      = SIC4_IMM_W,
   parameter int              DATA_W     = SIC4_DATA_W,
   parameter logic [OP_W-1:0] NOWRITE_OP = OP_W'(OP_NOWRITE),
   localparam int             INSTR_W    = OP_W + 2*REG_W + IMM_W,
   localparam int             NREG       = 2**REG_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OP_W-1:0]    op,
   output logic [REG_W-1:0]   rtd,
   output logic [REG_W-1:0]   rs,
   output logic [IMM_W-1:0]   fun_imm,
   output logic [DATA_W-1:0]  imm_sext,
   output logic               wr_en,
   input  logic               wb_valid,
   input  logic [REG_W-1:0]   wb_reg,
`ifdef DECODE_STAGE_PERF_EN
   output logic [15:0]        stall_cnt,
   output logic [15:0]        issue_cnt,
`endif
   output logic [NREG-1:0]    busy
);

   if (DATA_W < IMM_W) begin : g_bad_width
      $error("decode_stage: DATA_W must be >= IMM_W");
   end

   logic [OP_W-1:0]   instr_op_s;
   logic [REG_W-1:0]  instr_rtd_s;
   logic [REG_W-1:0]  instr_rs_s;
   logic [IMM_W-1:0]  instr_fun_s;
   logic              hit_rs_s;
   logic              hit_rtd_s;
   logic              hazard_s;
   logic              accept_s;
   logic              writes_s;

   logic              out_valid_q, out_valid_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [REG_W-1:0]  rtd_q, rtd_d;
   logic [REG_W-1:0]  rs_q, rs_d;
   logic [IMM_W-1:0]  fun_imm_q, fun_imm_d;
   logic [DATA_W-1:0] imm_sext_q, imm_sext_d;
   logic              wr_en_q, wr_en_d;

   assign instr_op_s  = instr[INSTR_W-1 -: OP_W];
   assign instr_rtd_s = instr[INSTR_W-OP_W-1 -: REG_W];
   assign instr_rs_s  = instr[IMM_W+REG_W-1 -: REG_W];
   assign instr_fun_s = instr[IMM_W-1:0];
   assign writes_s    = (instr_op_s != NOWRITE_OP);

   reg_scoreboard #(.REG_W(REG_W)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wb_valid (wb_valid),
      .wb_reg   (wb_reg),
      .set_en   (accept_s & writes_s),
      .set_reg  (instr_rtd_s),
      .rd_a     (instr_rs_s),
      .rd_b     (instr_rtd_s),
      .hit_a    (hit_rs_s),
      .hit_b    (hit_rtd_s),
      .busy     (busy)
   );

   // rtd is read as a source too (rtd = rtd op rs), which also covers WAW.
   assign hazard_s = hit_rs_s | hit_rtd_s;
   assign in_ready = ~rst & (~out_valid_q | out_ready) & ~hazard_s;
   assign accept_s = in_valid & in_ready;

   // Next-state for the decode register and handshake.
   always_comb begin
      out_valid_d = out_valid_q;
      op_d        = op_q;
      rtd_d       = rtd_q;
      rs_d        = rs_q;
      fun_imm_d   = fun_imm_q;
      imm_sext_d  = imm_sext_q;
      wr_en_d     = wr_en_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         op_d        = instr_op_s;
         rtd_d       = instr_rtd_s;
         rs_d        = instr_rs_s;
         fun_imm_d   = instr_fun_s;
         imm_sext_d  = DATA_W'($signed(instr_fun_s));
         wr_en_d     = writes_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Decode register; reset drops any in-flight instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         op_q        <= '0;
         rtd_q       <= '0;
         rs_q        <= '0;
         fun_imm_q   <= '0;
         imm_sext_q  <= '0;
         wr_en_q     <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         op_q        <= op_d;
         rtd_q       <= rtd_d;
         rs_q        <= rs_d;
         fun_imm_q   <= fun_imm_d;
         imm_sext_q  <= imm_sext_d;
         wr_en_q     <= wr_en_d;
      end
   end

   assign out_valid = out_valid_q;
   assign op        = op_q;
   assign rtd       = rtd_q;
   assign rs        = rs_q;
   assign fun_imm   = fun_imm_q;
   assign imm_sext  = imm_sext_q;
   assign wr_en     = wr_en_q;

`ifdef DECODE_STAGE_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] issue_cnt_q, issue_cnt_d;

   // Stall counter saturates; issue counter wraps.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      issue_cnt_d = issue_cnt_q;
      if (in_valid & hazard_s & ~rst & (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (accept_s) begin
         issue_cnt_d = issue_cnt_q + 16'd1;
      end else begin
         issue_cnt_d = issue_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         issue_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: expected decodes are queued on accept
// and compared when the stage presents them.
module tb_decode_stage;
   import sic4_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] instr = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] op, rtd, rs, fun_imm;
   logic [7:0] imm_sext;
   logic       wr_en;
   logic       wb_valid = 1'b0;
   logic [1:0] wb_reg = 2'd0;
   logic [3:0] busy;
`ifdef DECODE_STAGE_PERF_EN
   logic [15:0] stall_cnt, issue_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   decoded_t exp_q[$];
   decoded_t e;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op        (op),
      .rtd       (rtd),
      .rs        (rs),
      .fun_imm   (fun_imm),
      .imm_sext  (imm_sext),
      .wr_en     (wr_en),
      .wb_valid  (wb_valid),
      .wb_reg    (wb_reg),
`ifdef DECODE_STAGE_PERF_EN
      .stall_cnt (stall_cnt),
      .issue_cnt (issue_cnt),
`endif
      .busy      (busy)
   );

   function automatic decoded_t model(input logic [7:0] i);
      decoded_t m;
      m.op       = i[7:6];
      m.rtd      = i[5:4];
      m.rs       = i[3:2];
      m.fun_imm  = i[1:0];
      m.imm_sext = {{6{i[1]}}, i[1:0]};
      m.wr_en    = (i[7:6] != 2'b11);
      return m;
   endfunction

   // Record an accept into the scoreboard, then advance past the edge.
   task automatic cycle();
      if (in_valid && in_ready && !rst) exp_q.push_back(model(instr));
      @(posedge clk);
      #1;
   endtask

   task automatic pop_exp();
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++;
      if (busy !== 4'b0000) begin n_bad++; $display("FAIL reset_busy: got %b want 0000", busy); end
      n_cmp++;
      if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== 17'h0) begin
         n_bad++; $display("FAIL reset_fields: got %h want 0", {op, rtd, rs, fun_imm, imm_sext, wr_en});
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_stream();
      logic [7:0] ins [3] = '{8'h41, 8'h92, 8'h23};
      logic       wbv [3] = '{1'b0, 1'b1, 1'b1};
      logic [1:0] wbr [3] = '{2'd0, 2'd0, 2'd1};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         instr = ins[i]; in_valid = 1'b1; wb_valid = wbv[i]; wb_reg = wbr[i];
         #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
         cycle();
         n_cmp++;
         if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_out_valid[%0d]: got %b want 1", i, out_valid); end
         pop_exp();
         n_cmp++;
         if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== e) begin
            n_bad++; $display("FAIL stream_fields[%0d]: got %h want %h", i, {op, rtd, rs, fun_imm, imm_sext, wr_en}, e);
         end
      end
      in_valid = 1'b0; wb_valid = 1'b1; wb_reg = 2'd2;
      #1;
      cycle();
      wb_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
      n_cmp++;
      if (busy !== 4'b0000) begin n_bad++; $display("FAIL stream_drain_busy: got %b want 0000", busy); end
   endtask

   task automatic test_sext();
      instr = 8'h4B; in_valid = 1'b1;
      #1;
      cycle();
      in_valid = 1'b0;
      pop_exp();
      n_cmp++;
      if (imm_sext !== 8'hFF) begin n_bad++; $display("FAIL sext_value: got %h want ff", imm_sext); end
      n_cmp++;
      if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== e) begin
         n_bad++; $display("FAIL sext_fields: got %h want %h", {op, rtd, rs, fun_imm, imm_sext, wr_en}, e);
      end
      wb_valid = 1'b1; wb_reg = 2'd0;
      #1;
      cycle();
      wb_valid = 1'b0;
   endtask

   task automatic test_raw();
      instr = 8'h50; in_valid = 1'b1;
      #1;
      cycle();
      pop_exp();
      n_cmp++;
      if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== e) begin
         n_bad++; $display("FAIL raw_first: got %h want %h", {op, rtd, rs, fun_imm, imm_sext, wr_en}, e);
      end
      instr = 8'h04;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall_ready: got %b want 0", in_ready); end
      n_cmp++;
      if (busy !== 4'b0010) begin n_bad++; $display("FAIL raw_busy: got %b want 0010", busy); end
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL raw_bubble: got %b want 0", out_valid); end
      wb_valid = 1'b1; wb_reg = 2'd1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready: got %b want 1", in_ready); end
      cycle();
      in_valid = 1'b0; wb_valid = 1'b0;
      pop_exp();
      n_cmp++;
      if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== e) begin
         n_bad++; $display("FAIL raw_second: got %h want %h", {op, rtd, rs, fun_imm, imm_sext, wr_en}, e);
      end
      n_cmp++;
      if (busy !== 4'b0001) begin n_bad++; $display("FAIL raw_busy_after: got %b want 0001", busy); end
      wb_valid = 1'b1; wb_reg = 2'd0;
      #1;
      cycle();
      wb_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      decoded_t held;
      instr = 8'hC1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      cycle();
      pop_exp();
      held = e;
      n_cmp++;
      if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== held) begin
         n_bad++; $display("FAIL bp_first: got %h want %h", {op, rtd, rs, fun_imm, imm_sext, wr_en}, held);
      end
      out_ready = 1'b0; instr = 8'hC2;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
         cycle();
         n_cmp++;
         if ({out_valid, op, rtd, rs, fun_imm, imm_sext, wr_en} !== {1'b1, held}) begin
            n_bad++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {out_valid, op, rtd, rs, fun_imm, imm_sext, wr_en}, {1'b1, held});
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      cycle();
      in_valid = 1'b0;
      pop_exp();
      n_cmp++;
      if ({out_valid, op, rtd, rs, fun_imm, imm_sext, wr_en} !== {1'b1, e}) begin
         n_bad++; $display("FAIL bp_next: got %h want %h", {out_valid, op, rtd, rs, fun_imm, imm_sext, wr_en}, {1'b1, e});
      end
      #1;
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_collision();
      instr = 8'h20; in_valid = 1'b1;
      #1;
      cycle();
      pop_exp();
      n_cmp++;
      if (busy !== 4'b0100) begin n_bad++; $display("FAIL coll_busy_pre: got %b want 0100", busy); end
      instr = 8'h2A; wb_valid = 1'b1; wb_reg = 2'd2;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL coll_ready: got %b want 1", in_ready); end
      cycle();
      in_valid = 1'b0; wb_valid = 1'b0;
      pop_exp();
      n_cmp++;
      if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== e) begin
         n_bad++; $display("FAIL coll_fields: got %h want %h", {op, rtd, rs, fun_imm, imm_sext, wr_en}, e);
      end
      n_cmp++;
      if (busy !== 4'b0100) begin n_bad++; $display("FAIL coll_busy_post: got %b want 0100", busy); end
      wb_valid = 1'b1; wb_reg = 2'd2;
      #1;
      cycle();
      wb_valid = 1'b0;
      n_cmp++;
      if (busy !== 4'b0000) begin n_bad++; $display("FAIL coll_busy_clear: got %b want 0000", busy); end
   endtask

   task automatic test_reset_mid();
      instr = 8'h50; in_valid = 1'b1;
      #1;
      cycle();
      pop_exp();
      instr = 8'h70;
      #1;
      cycle();
      pop_exp();
      n_cmp++;
      if ({out_valid, busy} !== {1'b1, 4'b1010}) begin
         n_bad++; $display("FAIL mid_pre: got %b want 11010", {out_valid, busy});
      end
      instr = 8'h40; rst = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b want 0", in_ready); end
      cycle();
      rst = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, busy} !== 5'b0) begin n_bad++; $display("FAIL mid_state: got %b want 00000", {out_valid, busy}); end
      n_cmp++;
      if ({op, rtd, rs, fun_imm, imm_sext, wr_en} !== 17'h0) begin
         n_bad++; $display("FAIL mid_fields: got %h want 0", {op, rtd, rs, fun_imm, imm_sext, wr_en});
      end
`ifdef DECODE_STAGE_PERF_EN
      n_cmp++;
      if ({stall_cnt, issue_cnt} !== 32'h0) begin
         n_bad++; $display("FAIL mid_counters: got %h want 0", {stall_cnt, issue_cnt});
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_sext();
      test_raw();
      test_backpressure();
      test_collision();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
